// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 DIT FFT: transform size, state encoding and
// the default pipeline drain depth.
package fft_pkg;

   localparam int N     = 32;
   localparam int LOG2N = $clog2(N);

   localparam int MULT_LATENCY         = 2;
   localparam int DRAIN_CYCLES_DEFAULT = MULT_LATENCY + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int stage_width(input int aw);
      return (aw > 1) ? $clog2(aw) : 1;
   endfunction

endpackage

// File: rtl/fft_addr_calc.sv
// Combinational mapping of (stage, butterfly index) to the two sample
// addresses and the twiddle index of an in-place radix-2 DIT butterfly.
module fft_addr_calc
   import fft_pkg::*;
#(
   parameter int  ADDR_W = LOG2N,
   localparam int SW     = stage_width(ADDR_W)
) (
   input  logic [SW-1:0]     i_s,
   input  logic [ADDR_W-2:0] i_j,
   output logic [ADDR_W-1:0] o_addr1,
   output logic [ADDR_W-1:0] o_addr2,
   output logic [ADDR_W-2:0] o_tw
);

   localparam int SHW = SW + 1;

   logic [ADDR_W-1:0] w_j_ext;
   logic [ADDR_W-1:0] w_span;
   logic [ADDR_W-1:0] w_mask;
   logic [ADDR_W-1:0] w_pos;
   logic [ADDR_W-1:0] w_grp;
   logic [SHW-1:0]    w_sh_grp;
   logic [SHW-1:0]    w_sh_tw;

   assign w_j_ext  = {1'b0, i_j};
   assign w_span   = ADDR_W'(1) << i_s;
   assign w_mask   = w_span - 1'b1;
   assign w_pos    = w_j_ext & w_mask;
   assign w_grp    = w_j_ext >> i_s;
   // s+1 can reach ADDR_W, so the shift amounts carry one extra bit
   assign w_sh_grp = {1'b0, i_s} + 1'b1;
   assign w_sh_tw  = SHW'(ADDR_W - 1) - {1'b0, i_s};

   assign o_addr1  = (w_grp << w_sh_grp) | w_pos;
   assign o_addr2  = o_addr1 + w_span;
   assign o_tw     = (i_j & w_mask[ADDR_W-2:0]) << w_sh_tw;

endmodule

// File: rtl/fft_agu.sv
// Butterfly sequencer: walks every stage of the FFT, issuing one address pair
// per cycle, with a drain gap between stages so write-backs land first.
module fft_agu
   import fft_pkg::*;
#(
   parameter int N             = fft_pkg::N,
   parameter int address_width = $clog2(N),
   parameter int drain_cycles  = DRAIN_CYCLES_DEFAULT
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             hold,
   output logic [address_width-1:0]         rd_address1,
   output logic [address_width-1:0]         rd_address2,
   output logic [address_width-2:0]         tw_address,
   output logic [$clog2(address_width)-1:0] stage,
   output logic                             o_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int SW = $clog2(address_width);
   localparam int JW = address_width - 1;
   localparam int DW = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;

   localparam logic [JW-1:0] J_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(address_width - 1);
   localparam logic [DW-1:0] D_LAST = DW'(drain_cycles - 1);

   logic [1:0]               r_state, w_state_next;
   logic [JW-1:0]            r_j, w_j_next;
   logic [SW-1:0]            r_s, w_s_next;
   logic [DW-1:0]            r_drain, w_drain_next;
   logic                     w_valid_next;

   logic [address_width-1:0] r_addr1, r_addr2;
   logic [address_width-2:0] r_tw;
   logic [SW-1:0]            r_stage;
   logic                     r_valid, r_busy, r_done;

   logic [address_width-1:0] w_addr1, w_addr2;
   logic [address_width-2:0] w_tw;

   // r_j/r_s name the butterfly presented on the outputs (or pending, when held)
   always_comb begin
      w_state_next = r_state;
      w_j_next     = r_j;
      w_s_next     = r_s;
      w_drain_next = r_drain;
      w_valid_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_RUN;
               w_j_next     = '0;
               w_s_next     = '0;
               w_valid_next = ~hold;
            end
         end
         ST_RUN: begin
            if (r_valid && r_j == J_LAST) begin
               w_state_next = ST_DRAIN;
               w_j_next     = '0;
               w_drain_next = '0;
            end else begin
               if (r_valid)
                  w_j_next = r_j + 1'b1;
               w_valid_next = ~hold;
            end
         end
         ST_DRAIN: begin
            if (r_drain == D_LAST) begin
               w_drain_next = '0;
               if (r_s == S_LAST) begin
                  w_state_next = ST_DONE;
                  w_s_next     = '0;
               end else begin
                  w_state_next = ST_RUN;
                  w_s_next     = r_s + 1'b1;
                  w_valid_next = ~hold;
               end
            end else begin
               w_drain_next = r_drain + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   fft_addr_calc #(
      .ADDR_W (address_width)
   ) u_addr_calc (
      .i_s     (w_s_next),
      .i_j     (w_j_next),
      .o_addr1 (w_addr1),
      .o_addr2 (w_addr2),
      .o_tw    (w_tw)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_j     <= '0;
         r_s     <= '0;
         r_drain <= '0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_tw    <= '0;
         r_stage <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_j     <= w_j_next;
         r_s     <= w_s_next;
         r_drain <= w_drain_next;
         r_valid <= w_valid_next;
         r_busy  <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
         r_done  <= (w_state_next == ST_DONE);
         // addresses and stage move only with an issued butterfly
         if (w_valid_next) begin
            r_addr1 <= w_addr1;
            r_addr2 <= w_addr2;
            r_tw    <= w_tw;
            r_stage <= w_s_next;
         end
      end
   end

   assign rd_address1 = r_addr1;
   assign rd_address2 = r_addr2;
   assign tw_address  = r_tw;
   assign stage       = r_stage;
   assign o_valid     = r_valid;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: N=8 scenario table with a butterfly
// scoreboard, reset abort sequence, and a full N=32 run.
module tb_fft_agu;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // N = 8 instance
   logic       rst8, start8, hold8;
   logic [2:0] a1_8, a2_8;
   logic [1:0] tw8, st8;
   logic       v8, b8, d8;

   // N = 32 instance
   logic       rst32, start32, hold32;
   logic [4:0] a1_32, a2_32;
   logic [3:0] tw32;
   logic [2:0] st32;
   logic       v32, b32, d32;

   fft_agu #(.N(8), .drain_cycles(4)) u_dut8 (
      .clk(clk), .reset(rst8), .start(start8), .hold(hold8),
      .rd_address1(a1_8), .rd_address2(a2_8), .tw_address(tw8), .stage(st8),
      .o_valid(v8), .busy(b8), .done(d8)
   );

   fft_agu #(.N(32), .drain_cycles(4)) u_dut32 (
      .clk(clk), .reset(rst32), .start(start32), .hold(hold32),
      .rd_address1(a1_32), .rd_address2(a2_32), .tw_address(tw32), .stage(st32),
      .o_valid(v32), .busy(b32), .done(d32)
   );

   typedef struct {
      logic [2:0] a1;
      logic [2:0] a2;
      logic [1:0] tw;
      logic [1:0] st;
   } vec8_t;

   typedef struct {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [3:0] tw;
      logic [2:0] st;
   } vec32_t;

   // scenario inputs (hold window, extra start pulses) and expected timing
   typedef struct {
      int h0;
      int hl;
      int s1;
      int s2;
      int s3;
      int first;
      int done_c;
   } scn_t;

   vec8_t  tbl8 [12];
   scn_t   scn  [4];
   vec8_t  q8   [$];
   vec32_t q32  [$];

   bit exp_v [0:63];
   bit exp_b [0:63];
   bit exp_d [0:63];

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Timing model: hold seen in cycle c-1 blocks an issue in cycle c
   function automatic void build8(input int h0, input int hl);
      int c;
      for (int i = 0; i < 64; i++) begin
         exp_v[i] = 1'b0; exp_b[i] = 1'b0; exp_d[i] = 1'b0;
      end
      c = 1;
      for (int s = 0; s < 3; s++) begin
         for (int j = 0; j < 4; j++) begin
            while ((c - 1 >= h0) && (c - 1 < h0 + hl)) begin
               exp_b[c] = 1'b1;
               c++;
            end
            exp_v[c] = 1'b1;
            exp_b[c] = 1'b1;
            c++;
         end
         for (int d = 0; d < 4; d++) begin
            exp_b[c] = 1'b1;
            c++;
         end
      end
      exp_d[c] = 1'b1;
   endfunction

   task automatic run8(input int k);
      vec8_t e;
      int    c_first, c_done, nb;
      build8(scn[k].h0, scn[k].hl);
      for (int i = 0; i < 12; i++) q8.push_back(tbl8[i]);
      c_first = -1;
      c_done  = -1;
      nb      = 0;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (c > 0) begin
            chk($sformatf("sc%0d cyc%0d valid/busy/done", k, c),
                {61'd0, v8, b8, d8}, {61'd0, exp_v[c], exp_b[c], exp_d[c]});
            if (v8 === 1'b1) begin
               if (c_first < 0) c_first = c;
               if (q8.size() == 0) begin
                  chk($sformatf("sc%0d cyc%0d extra butterfly", k, c), 64'd1, 64'd0);
               end else begin
                  e = q8.pop_front();
                  chk($sformatf("sc%0d bfly%0d a1/a2/tw/stage", k, nb),
                      {54'd0, a1_8, a2_8, tw8, st8}, {54'd0, e.a1, e.a2, e.tw, e.st});
                  nb++;
               end
            end
            if (d8 === 1'b1) c_done = c;
         end
         start8 = (c == 0) || (c == scn[k].s1) || (c == scn[k].s2) || (c == scn[k].s3);
         hold8  = (c >= scn[k].h0) && (c < scn[k].h0 + scn[k].hl);
      end
      start8 = 1'b0;
      hold8  = 1'b0;
      chk($sformatf("sc%0d first valid cycle", k), 64'(c_first), 64'(scn[k].first));
      chk($sformatf("sc%0d done cycle", k), 64'(c_done), 64'(scn[k].done_c));
      chk($sformatf("sc%0d leftover butterflies", k), 64'(q8.size()), 64'd0);
      q8.delete();
      $display("scenario %0d: %0d butterflies, first valid %0d, done %0d", k, nb, c_first, c_done);
   endtask

   task automatic reset_abort8();
      int bad;
      for (int c = 0; c <= 18; c++) begin
         @(negedge clk);
         start8 = (c == 0);
      end
      // cycle 18: stage 2, j = 1 -> (1,5)
      chk("abort pre-reset butterfly", {56'd0, v8, st8, a1_8, a2_8}, {56'd0, 1'b1, 2'd2, 3'd1, 3'd5});
      #1 rst8 = 1'b1;
      #1;
      chk("abort async clear", {49'd0, a1_8, a2_8, tw8, st8, v8, b8, d8}, 64'd0);
      @(negedge clk);
      rst8 = 1'b0;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (v8 !== 1'b0 || b8 !== 1'b0 || d8 !== 1'b0) bad++;
      end
      chk("abort quiet after reset (no done)", 64'(bad), 64'd0);
      $display("reset abort: %0d non-idle cycles after reset", bad);
   endtask

   task automatic run32();
      vec32_t      e;
      logic [31:0] seen [5];
      int          n_valid, c_done, dups, nb;
      for (int s = 0; s < 5; s++) begin
         seen[s] = '0;
         for (int g = 0; g < (16 >> s); g++) begin
            for (int p = 0; p < (1 << s); p++) begin
               e.a1 = 5'(g * 2 * (1 << s) + p);
               e.a2 = 5'(g * 2 * (1 << s) + p + (1 << s));
               e.tw = 4'(p * (16 >> s));
               e.st = 3'(s);
               q32.push_back(e);
            end
         end
      end
      n_valid = 0;
      c_done  = -1;
      dups    = 0;
      nb      = 0;
      for (int c = 0; c <= 110; c++) begin
         @(negedge clk);
         if (c > 0) begin
            if (v32 === 1'b1) begin
               n_valid++;
               if (q32.size() == 0) begin
                  chk($sformatf("n32 cyc%0d extra butterfly", c), 64'd1, 64'd0);
               end else begin
                  e = q32.pop_front();
                  chk($sformatf("n32 bfly%0d a1/a2/tw/stage", nb),
                      {47'd0, a1_32, a2_32, tw32, st32}, {47'd0, e.a1, e.a2, e.tw, e.st});
                  chk($sformatf("n32 bfly%0d span", nb), 64'(5'(a2_32 - a1_32)), 64'(1 << e.st));
                  if (seen[e.st][a1_32] || seen[e.st][a2_32]) dups++;
                  seen[e.st][a1_32] = 1'b1;
                  seen[e.st][a2_32] = 1'b1;
                  nb++;
               end
            end
            if (d32 === 1'b1) c_done = c;
         end
         start32 = (c == 0);
      end
      start32 = 1'b0;
      chk("n32 valid count", 64'(n_valid), 64'd80);
      chk("n32 done cycle", 64'(c_done), 64'd101);
      chk("n32 duplicate addresses", 64'(dups), 64'd0);
      for (int s = 0; s < 5; s++)
         chk($sformatf("n32 stage%0d coverage", s), 64'(seen[s]), 64'hFFFF_FFFF);
      q32.delete();
      $display("n32 run: %0d butterflies, done %0d", n_valid, c_done);
   endtask

   initial begin
      tbl8[0]  = '{3'd0, 3'd1, 2'd0, 2'd0};
      tbl8[1]  = '{3'd2, 3'd3, 2'd0, 2'd0};
      tbl8[2]  = '{3'd4, 3'd5, 2'd0, 2'd0};
      tbl8[3]  = '{3'd6, 3'd7, 2'd0, 2'd0};
      tbl8[4]  = '{3'd0, 3'd2, 2'd0, 2'd1};
      tbl8[5]  = '{3'd1, 3'd3, 2'd2, 2'd1};
      tbl8[6]  = '{3'd4, 3'd6, 2'd0, 2'd1};
      tbl8[7]  = '{3'd5, 3'd7, 2'd2, 2'd1};
      tbl8[8]  = '{3'd0, 3'd4, 2'd0, 2'd2};
      tbl8[9]  = '{3'd1, 3'd5, 2'd1, 2'd2};
      tbl8[10] = '{3'd2, 3'd6, 2'd2, 2'd2};
      tbl8[11] = '{3'd3, 3'd7, 2'd3, 2'd2};

      //         h0  hl  s1  s2  s3 first done
      scn[0] = '{ 0,  0, -1, -1, -1,   1,  25};
      scn[1] = '{10,  3, -1, -1, -1,   1,  28};
      scn[2] = '{ 0,  0,  2,  6, 25,   1,  25};
      scn[3] = '{ 0,  2, -1, -1, -1,   3,  27};

      rst8 = 1'b1; start8 = 1'b0; hold8 = 1'b0;
      rst32 = 1'b1; start32 = 1'b0; hold32 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset n8 outputs", {49'd0, a1_8, a2_8, tw8, st8, v8, b8, d8}, 64'd0);
      chk("reset n32 outputs", {44'd0, a1_32, a2_32, tw32, st32, v32, b32, d32}, 64'd0);
      rst8 = 1'b0;
      rst32 = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 4; k++) run8(k);
      reset_abort8();
      run8(0);
      run32();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
